prbs24_checker: RTL and testbench

Receive-side checker for the 24-bit parallel PRBS stream produced by the team's 24-bit LFSR pattern generator (polynomial x^24+x^23+x^22+x^17+1, one 24-bit word per clock). It self-synchronizes to the incoming words, declares lock, then counts word and bit errors against an internally advanced expected pattern. It sits after the link/deserializer in PRBS test mode, and its counters are read by slow control.

---
 rtl/prbs24_checker.sv | 195 +++++++++++++++++++
 tb/tb_prbs24_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs24_checker.sv
// prbs24_checker
//   Receive-side checker for the 24-bit parallel PRBS stream
//   (x^24+x^23+x^22+x^17+1, one word per clock). Self-synchronizes by
//   seeding its expected word from received data, declares lock after
//   LOCK_CNT consecutive matches, then counts word/bit errors against a
//   self-advancing expected pattern.
//
// Ports
//   CLK        clock
//   RST        asynchronous, active-high reset
//   DIN        received 24-bit word
//   DIN_VALID  DIN valid this cycle; when low all state holds
//   CLR_CNT    synchronous clear of ERR_WORDS / ERR_BITS / WORD_CNT
//   LOCKED     checker is locked
//   ERR        one-cycle pulse: previous valid word (checked in LOCKED) mismatched
//   ERR_WORDS  errored words while LOCKED (saturating)
//   ERR_BITS   errored bits while LOCKED (saturating)
//   WORD_CNT   words checked while LOCKED (saturating)

// Saturating accumulator: cnt += inc when en, clamped at all-ones.
// clr has priority over an update in the same cycle.
module prbs24_sat_acc #(
    parameter int CNT_W = 32,
    parameter int INC_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);
    // One spare bit beyond the widest operand so the sum never wraps.
    localparam int SW = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    logic [SW-1:0] sum;
    logic          ovf;

    assign sum = SW'(cnt) + SW'(inc);
    assign ovf = (sum > SW'({CNT_W{1'b1}}));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= ovf ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
endmodule

module prbs24_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [23:0]      DIN,
    input  logic             DIN_VALID,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_WORDS,
    output logic [CNT_W-1:0] ERR_BITS,
    output logic [CNT_W-1:0] WORD_CNT
);
    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    // Next parallel word of the generator (24 serial steps folded).
    function automatic logic [23:0] next_word(input logic [23:0] s);
        logic [23:0] n;
        n[0] = s[10] ^ s[17] ^ s[20] ^ s[23] ^ s[0];
        n[1] = s[11] ^ s[17] ^ s[18] ^ s[21] ^ s[22] ^ s[23] ^ s[0] ^ s[1];
        for (int i = 2; i <= 6; i++)
            n[i] = s[i+10] ^ s[i+15] ^ s[i+16] ^ s[i+17] ^ s[i-2] ^ s[i-1] ^ s[i];
        for (int i = 7; i <= 23; i++)
            n[i] = s[i-7] ^ s[i-2] ^ s[i-1] ^ s[i];
        return n;
    endfunction

    function automatic logic [4:0] popcount24(input logic [23:0] d);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 24; i++)
            c = c + 5'(d[i]);
        return c;
    endfunction

    state_t      state_q;
    logic [23:0] exp_q;
    logic        seeded_q;
    logic [7:0]  match_q;
    logic [7:0]  bad_q;

    logic [23:0] diff;
    logic        mism;
    logic [4:0]  nbits;
    logic        chk;
    logic        err_now;
    logic [8:0]  match_inc;
    logic [8:0]  bad_inc;

    assign diff      = DIN ^ exp_q;
    assign mism      = |diff;
    assign nbits     = popcount24(diff);
    assign chk       = DIN_VALID && (state_q == S_LOCKED);
    assign err_now   = chk && mism;
    assign match_inc = {1'b0, match_q} + 9'd1;
    assign bad_inc   = {1'b0, bad_q} + 9'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_SEARCH;
            exp_q    <= '0;
            seeded_q <= 1'b0;
            match_q  <= '0;
            bad_q    <= '0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            ERR <= err_now;
            if (DIN_VALID) begin
                case (state_q)
                    S_SEARCH: begin
                        // Reseed from received data every word; the
                        // all-zero word is a fixed point of the
                        // generator and must never count as a match.
                        exp_q    <= next_word(DIN);
                        seeded_q <= 1'b1;
                        if (seeded_q && !mism && (DIN != 24'd0)) begin
                            if (match_inc == 9'(LOCK_CNT)) begin
                                state_q <= S_LOCKED;
                                LOCKED  <= 1'b1;
                                match_q <= '0;
                                bad_q   <= '0;
                            end else begin
                                match_q <= match_inc[7:0];
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    S_LOCKED: begin
                        // Free-running expectation: errored words never
                        // disturb the reference while locked.
                        exp_q <= next_word(exp_q);
                        if (mism) begin
                            if (bad_inc == 9'(UNLOCK_CNT)) begin
                                state_q <= S_SEARCH;
                                LOCKED  <= 1'b0;
                                match_q <= '0;
                                bad_q   <= '0;
                                // Resume searching seeded by this word.
                                exp_q   <= next_word(DIN);
                            end else begin
                                bad_q <= bad_inc[7:0];
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: state_q <= S_SEARCH;
                endcase
            end
        end
    end

    prbs24_sat_acc #(.CNT_W(CNT_W), .INC_W(1)) u_word_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (CLR_CNT),
        .en  (chk),
        .inc (1'b1),
        .cnt (WORD_CNT)
    );

    prbs24_sat_acc #(.CNT_W(CNT_W), .INC_W(1)) u_err_words (
        .CLK (CLK),
        .RST (RST),
        .clr (CLR_CNT),
        .en  (err_now),
        .inc (1'b1),
        .cnt (ERR_WORDS)
    );

    prbs24_sat_acc #(.CNT_W(CNT_W), .INC_W(5)) u_err_bits (
        .CLK (CLK),
        .RST (RST),
        .clr (CLR_CNT),
        .en  (err_now),
        .inc (nbits),
        .cnt (ERR_BITS)
    );
endmodule

// File: tb/tb_prbs24_checker.sv
// Testbench for prbs24_checker: directed scenarios on a default-parameter
// instance plus a CNT_W=4 / UNLOCK_CNT=255 instance for saturation.
module tb_prbs24_checker;
    logic        CLK = 1'b0;
    logic        RST;
    logic [23:0] din, din_s;
    logic        din_valid, din_valid_s, clr_cnt, clr_cnt_s;
    logic        locked, err, locked_s, err_s;
    logic [31:0] err_words, err_bits, word_cnt;
    logic [3:0]  err_words_s, err_bits_s, word_cnt_s;

    int checks = 0;
    int failures = 0;
    logic [23:0] g;

    always #5 CLK = ~CLK;

    prbs24_checker dut (
        .CLK(CLK), .RST(RST), .DIN(din), .DIN_VALID(din_valid), .CLR_CNT(clr_cnt),
        .LOCKED(locked), .ERR(err), .ERR_WORDS(err_words), .ERR_BITS(err_bits),
        .WORD_CNT(word_cnt)
    );

    prbs24_checker #(.LOCK_CNT(8), .UNLOCK_CNT(255), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .DIN(din_s), .DIN_VALID(din_valid_s), .CLR_CNT(clr_cnt_s),
        .LOCKED(locked_s), .ERR(err_s), .ERR_WORDS(err_words_s), .ERR_BITS(err_bits_s),
        .WORD_CNT(word_cnt_s)
    );

    function automatic logic [23:0] f(input logic [23:0] s);
        logic [23:0] n;
        n[0] = s[10] ^ s[17] ^ s[20] ^ s[23] ^ s[0];
        n[1] = s[11] ^ s[17] ^ s[18] ^ s[21] ^ s[22] ^ s[23] ^ s[0] ^ s[1];
        for (int i = 2; i <= 6; i++)
            n[i] = s[i+10] ^ s[i+15] ^ s[i+16] ^ s[i+17] ^ s[i-2] ^ s[i-1] ^ s[i];
        for (int i = 7; i <= 23; i++)
            n[i] = s[i-7] ^ s[i-2] ^ s[i-1] ^ s[i];
        return n;
    endfunction

    task automatic step(input logic [23:0] d, input logic v, input logic c);
        din = d; din_valid = v; clr_cnt = c;
        @(posedge CLK); #1;
        din_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic step_s(input logic [23:0] d, input logic v);
        din_s = d; din_valid_s = v;
        @(posedge CLK); #1;
        din_valid_s = 1'b0;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // Send the next generator word, optionally corrupted.
    task automatic gen_step(input logic [23:0] mask);
        logic [23:0] w;
        w = g; g = f(g);
        step(w ^ mask, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked: got %0d want 0", locked); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0d want 0", err); end
        checks++; if (err_words !== 32'd0 || err_bits !== 32'd0 || word_cnt !== 32'd0) begin
            failures++; $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", err_words, err_bits, word_cnt);
        end
        RST = 1'b0;
    endtask

    task automatic test_clean_lock();
        int pulses;
        g = 24'h4DB62E;
        for (int k = 0; k < 8; k++) gen_step(24'h0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %0d want 0", locked); end
        gen_step(24'h0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_9th: got %0d want 1", locked); end
        pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            gen_step(24'h0);
            if (err === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL clean_err_pulses: got %0d want 0", pulses); end
        checks++; if (err_words !== 32'd0) begin failures++; $display("FAIL clean_err_words: got %0d want 0", err_words); end
        checks++; if (err_bits !== 32'd0) begin failures++; $display("FAIL clean_err_bits: got %0d want 0", err_bits); end
        checks++; if (word_cnt !== 32'd1000) begin failures++; $display("FAIL clean_word_cnt: got %0d want 1000", word_cnt); end
    endtask

    task automatic test_inject();
        gen_step(24'h000020);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL inj1_err: got %0d want 1", err); end
        checks++; if (err_words !== 32'd1 || err_bits !== 32'd1) begin
            failures++; $display("FAIL inj1_counts: got %0d/%0d want 1/1", err_words, err_bits);
        end
        gen_step(24'h0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL inj1_next_err: got %0d want 0", err); end
        for (int k = 0; k < 4; k++) gen_step(24'h0);
        gen_step(24'h000007);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL inj2_err: got %0d want 1", err); end
        for (int k = 0; k < 3; k++) gen_step(24'h0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL inj2_next_err: got %0d want 0", err); end
        checks++; if (err_words !== 32'd2 || err_bits !== 32'd4) begin
            failures++; $display("FAIL inj_totals: got %0d/%0d want 2/4", err_words, err_bits);
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL inj_locked: got %0d want 1", locked); end
        checks++; if (word_cnt !== 32'd1010) begin failures++; $display("FAIL inj_word_cnt: got %0d want 1010", word_cnt); end
    endtask

    task automatic test_loss_relock();
        logic [23:0] masks [4];
        masks = '{24'hFFFFFF, 24'h000001, 24'h0F0F0F, 24'h800000};
        step(24'h0, 1'b0, 1'b1);
        checks++; if (err_words !== 32'd0 || err_bits !== 32'd0 || word_cnt !== 32'd0) begin
            failures++; $display("FAIL clr_idle: got %0d/%0d/%0d want 0/0/0", err_words, err_bits, word_cnt);
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clr_keeps_lock: got %0d want 1", locked); end
        for (int k = 0; k < 3; k++) gen_step(masks[k]);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL loss_3bad: got %0d want 1", locked); end
        gen_step(masks[3]);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_4bad: got %0d want 0", locked); end
        checks++; if (err_words !== 32'd4 || err_bits !== 32'd38 || word_cnt !== 32'd4) begin
            failures++; $display("FAIL loss_counts: got %0d/%0d/%0d want 4/38/4", err_words, err_bits, word_cnt);
        end
        for (int k = 0; k < 8; k++) gen_step(24'h0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL relock_early: got %0d want 0", locked); end
        gen_step(24'h0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock: got %0d want 1", locked); end
        checks++; if (err_words !== 32'd4 || word_cnt !== 32'd4) begin
            failures++; $display("FAIL relock_retain: got %0d/%0d want 4/4", err_words, word_cnt);
        end
    endtask

    task automatic test_zero_input();
        int seen_lock;
        int pulses;
        pulse_reset();
        seen_lock = 0; pulses = 0;
        for (int k = 0; k < 100; k++) begin
            step(24'h0, 1'b1, 1'b0);
            if (locked === 1'b1) seen_lock++;
            if (err === 1'b1) pulses++;
        end
        checks++; if (seen_lock != 0) begin failures++; $display("FAIL zero_locked: got %0d cycles want 0", seen_lock); end
        checks++; if (pulses != 0) begin failures++; $display("FAIL zero_err: got %0d want 0", pulses); end
        checks++; if (err_words !== 32'd0 || err_bits !== 32'd0 || word_cnt !== 32'd0) begin
            failures++; $display("FAIL zero_counters: got %0d/%0d/%0d want 0/0/0", err_words, err_bits, word_cnt);
        end
    endtask

    task automatic test_gaps_clear();
        int nv;
        int pulses;
        pulse_reset();
        g = 24'h4DB62E;
        nv = 0; pulses = 0;
        for (int c = 0; c < 400 && nv < 30; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_step(24'h0);
                nv++;
            end else begin
                step(24'($urandom), 1'b0, 1'b0);
            end
            if (err === 1'b1) pulses++;
        end
        checks++; if (nv != 30) begin failures++; $display("FAIL gaps_budget: got %0d valid want 30", nv); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gaps_locked: got %0d want 1", locked); end
        checks++; if (pulses != 0 || err_words !== 32'd0) begin
            failures++; $display("FAIL gaps_errors: got %0d pulses %0d words want 0/0", pulses, err_words);
        end
        checks++; if (word_cnt !== 32'd21) begin failures++; $display("FAIL gaps_word_cnt: got %0d want 21", word_cnt); end
        begin
            logic [23:0] w;
            w = g; g = f(g);
            step(w ^ 24'h000001, 1'b1, 1'b1);
        end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL clr_err_pulse: got %0d want 1", err); end
        checks++; if (err_words !== 32'd0 || err_bits !== 32'd0 || word_cnt !== 32'd0) begin
            failures++; $display("FAIL clr_wins: got %0d/%0d/%0d want 0/0/0", err_words, err_bits, word_cnt);
        end
        gen_step(24'h0);
        checks++; if (err !== 1'b0 || word_cnt !== 32'd1 || err_words !== 32'd0) begin
            failures++; $display("FAIL clr_after: got err %0d wc %0d ew %0d want 0/1/0", err, word_cnt, err_words);
        end
    endtask

    task automatic test_sat_reset();
        logic [23:0] w;
        pulse_reset();
        g = 24'h4DB62E;
        for (int k = 0; k < 9; k++) begin
            w = g; g = f(g); step_s(w, 1'b1);
        end
        checks++; if (locked_s !== 1'b1) begin failures++; $display("FAIL sat_lock: got %0d want 1", locked_s); end
        for (int k = 0; k < 20; k++) begin
            w = g; g = f(g); step_s(w ^ 24'h000001, 1'b1);
        end
        checks++; if (err_words_s !== 4'd15 || err_bits_s !== 4'd15 || word_cnt_s !== 4'd15) begin
            failures++; $display("FAIL sat_counts: got %0d/%0d/%0d want 15/15/15", err_words_s, err_bits_s, word_cnt_s);
        end
        checks++; if (locked_s !== 1'b1) begin failures++; $display("FAIL sat_locked: got %0d want 1", locked_s); end
        // Assert reset between clock edges and look before any edge.
        #3 RST = 1'b1;
        #1;
        checks++; if (locked_s !== 1'b0 || err_s !== 1'b0 || err_words_s !== 4'd0 || err_bits_s !== 4'd0 || word_cnt_s !== 4'd0) begin
            failures++; $display("FAIL async_rst: got %0d/%0d/%0d/%0d/%0d want all 0",
                                 locked_s, err_s, err_words_s, err_bits_s, word_cnt_s);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        din = '0; din_valid = 1'b0; clr_cnt = 1'b0;
        din_s = '0; din_valid_s = 1'b0; clr_cnt_s = 1'b0;
        test_reset();
        test_clean_lock();
        test_inject();
        test_loss_relock();
        test_zero_input();
        test_gaps_clear();
        test_sat_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
